// File: rtl/ge_speed_sel.sv
// ge_speed_sel: debounced GMII/MII speed tracker with GE hold-off and a gated,
// glitch-safe sequence driving the 125 MHz / PHY TXCLK mux select.
module ge_speed_sel #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE     = 16,
    parameter int HOLD_CYCLES  = 24'hFFFFFF,
    parameter int GUARD_CYCLES = 8,
    parameter int TIMER_W      = 28
) (
    input  logic       SYS_CLK,
    input  logic       RESET,
    input  logic       GMII_GE_IND,
    input  logic       MII_100_IND,
    input  logic       FORCE_EN,
    input  logic [1:0] FORCE_MODE,
    output logic [1:0] SPEED,
    output logic       CLK_SEL,
    output logic       TX_CE,
    output logic       SWITCH_BUSY,
    output logic       LINK_CHANGE,
    output logic [7:0] SWITCH_CNT
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATE   = 2'd1;
    localparam logic [1:0] S_SWAP   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;
    localparam logic [1:0] GE       = 2'b10;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    logic [SYNC_STAGES-1:0] ge_sync, m100_sync;
    logic [1:0]             raw, cand, acc, tracked, target, state;
    logic [DW-1:0]          deb_cnt;
    logic [TIMER_W-1:0]     hold_tmr;
    logic [GW-1:0]          guard;
    logic                   ge_seen, hold_ge;

    assign raw         = ge_sync[SYNC_STAGES-1] ? GE : {1'b0, m100_sync[SYNC_STAGES-1]};
    assign hold_ge     = ge_seen && hold_tmr != TIMER_W'(HOLD_CYCLES);
    assign tracked     = (acc == GE || hold_ge) ? GE : acc;
    assign target      = FORCE_EN ? (FORCE_MODE[1] ? GE : FORCE_MODE) : tracked;
    assign SWITCH_BUSY = state != S_IDLE;

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            ge_sync   <= '0;
            m100_sync <= '0;
            cand      <= 2'b00;
            acc       <= 2'b00;
            deb_cnt   <= '0;
            hold_tmr  <= '0;
            ge_seen   <= 1'b0;
        end else begin
            ge_sync   <= {ge_sync[SYNC_STAGES-2:0], GMII_GE_IND};
            m100_sync <= {m100_sync[SYNC_STAGES-2:0], MII_100_IND};
            if (raw != cand) begin
                cand    <= raw;
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE - 1))
                acc <= cand;
            else
                deb_cnt <= deb_cnt + DW'(1);
            // ge_seen keeps a never-GE link from being held at GE out of reset
            if (acc == GE) begin
                hold_tmr <= '0;
                ge_seen  <= 1'b1;
            end else if (hold_ge)
                hold_tmr <= hold_tmr + TIMER_W'(1);
        end
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_SETTLE;
            guard       <= '0;
            SPEED       <= 2'b00;
            CLK_SEL     <= 1'b0;
            TX_CE       <= 1'b0;
            LINK_CHANGE <= 1'b0;
            SWITCH_CNT  <= 8'd0;
        end else begin
            LINK_CHANGE <= 1'b0;
            case (state)
                S_IDLE:
                    if (target != SPEED) begin
                        state <= S_GATE;
                        guard <= '0;
                        TX_CE <= 1'b0;
                    end
                S_GATE:
                    if (guard == GW'(GUARD_CYCLES - 1))
                        state <= S_SWAP;
                    else
                        guard <= guard + GW'(1);
                S_SWAP: begin
                    SPEED   <= target;
                    CLK_SEL <= target == GE;
                    guard   <= '0;
                    state   <= S_SETTLE;
                    if (target != SPEED) begin
                        LINK_CHANGE <= 1'b1;
                        SWITCH_CNT  <= SWITCH_CNT + {7'd0, SWITCH_CNT != 8'hFF};
                    end
                end
                default:
                    if (guard == GW'(GUARD_CYCLES - 1)) begin
                        state <= S_IDLE;
                        TX_CE <= 1'b1;
                    end else
                        guard <= guard + GW'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_ge_speed_sel.sv
// tb_ge_speed_sel: directed checks of reset, debounce, GE hold-off, override,
// counter saturation and asynchronous reset mid-switch.
module tb_ge_speed_sel;
    logic       SYS_CLK = 1'b0, RESET = 1'b1, GMII_GE_IND = 1'b0, MII_100_IND = 1'b0, FORCE_EN = 1'b0;
    logic [1:0] FORCE_MODE = 2'b00;
    logic [1:0] SPEED;
    logic       CLK_SEL, TX_CE, SWITCH_BUSY, LINK_CHANGE;
    logic [7:0] SWITCH_CNT;
    int         tests = 0, fails = 0;

    localparam int NT = 160;
    logic       tce_tr[NT];
    logic       sel_tr[NT];
    logic       lc_tr[NT];
    logic [1:0] spd_tr[NT];

    ge_speed_sel #(.SYNC_STAGES(2), .DEBOUNCE(4), .HOLD_CYCLES(100), .GUARD_CYCLES(3), .TIMER_W(28)) dut (
        .SYS_CLK(SYS_CLK), .RESET(RESET), .GMII_GE_IND(GMII_GE_IND), .MII_100_IND(MII_100_IND),
        .FORCE_EN(FORCE_EN), .FORCE_MODE(FORCE_MODE), .SPEED(SPEED), .CLK_SEL(CLK_SEL), .TX_CE(TX_CE),
        .SWITCH_BUSY(SWITCH_BUSY), .LINK_CHANGE(LINK_CHANGE), .SWITCH_CNT(SWITCH_CNT)
    );

    always #4 SYS_CLK = ~SYS_CLK;

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    // index i holds the outputs just after the i-th edge following the stimulus
    task automatic trace(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            tce_tr[i] = TX_CE;
            sel_tr[i] = CLK_SEL;
            lc_tr[i]  = LINK_CHANGE;
            spd_tr[i] = SPEED;
        end
    endtask

    task automatic test_reset();
        int lcs;
        RESET = 1'b1;
        repeat (3) tick();
        tests++; if (TX_CE !== 1'b0) begin fails++; $display("FAIL reset_tx_ce: got %b want 0", TX_CE); end
        tests++; if (SPEED !== 2'b00 || CLK_SEL !== 1'b0) begin fails++; $display("FAIL reset_speed_sel: got %b/%b want 00/0", SPEED, CLK_SEL); end
        tests++; if (SWITCH_BUSY !== 1'b1 || LINK_CHANGE !== 1'b0 || SWITCH_CNT !== 8'd0) begin fails++; $display("FAIL reset_status: got busy=%b lc=%b cnt=%0d want 1/0/0", SWITCH_BUSY, LINK_CHANGE, SWITCH_CNT); end
        @(negedge SYS_CLK) RESET = 1'b0;
        trace(8);
        lcs = 0;
        for (int i = 0; i < 8; i++) lcs += int'(lc_tr[i]);
        tests++; if (tce_tr[1] !== 1'b0 || tce_tr[2] !== 1'b1) begin fails++; $display("FAIL reset_release_tx_ce: got %b%b want 01", tce_tr[1], tce_tr[2]); end
        tests++; if (spd_tr[7] !== 2'b00 || sel_tr[7] !== 1'b0 || lcs != 0) begin fails++; $display("FAIL reset_release_idle: got spd=%b sel=%b lc=%0d want 00/0/0", spd_tr[7], sel_tr[7], lcs); end
    endtask

    task automatic test_ge_up();
        int lcs;
        GMII_GE_IND = 1'b1;
        trace(20);
        lcs = 0;
        for (int i = 0; i < 20; i++) lcs += int'(lc_tr[i]);
        tests++; if (tce_tr[6] !== 1'b1 || tce_tr[7] !== 1'b0) begin fails++; $display("FAIL ge_up_gate: got %b%b want 10", tce_tr[6], tce_tr[7]); end
        tests++; if (spd_tr[10] !== 2'b00 || spd_tr[11] !== 2'b10 || sel_tr[11] !== 1'b1) begin fails++; $display("FAIL ge_up_swap: got %b->%b sel=%b want 00->10 sel=1", spd_tr[10], spd_tr[11], sel_tr[11]); end
        tests++; if (lcs != 1 || lc_tr[11] !== 1'b1) begin fails++; $display("FAIL ge_up_link_change: got %0d pulses want 1 at edge 11", lcs); end
        tests++; if (tce_tr[13] !== 1'b0 || tce_tr[14] !== 1'b1) begin fails++; $display("FAIL ge_up_settle: got %b%b want 01", tce_tr[13], tce_tr[14]); end
        tests++; if (SWITCH_CNT !== 8'd1) begin fails++; $display("FAIL ge_up_cnt: got %0d want 1", SWITCH_CNT); end
    endtask

    task automatic test_ge_hold();
        int drops, lcs;
        drops = 0;
        GMII_GE_IND = 1'b0;
        trace(60);
        for (int i = 0; i < 60; i++) drops += int'(!tce_tr[i]);
        GMII_GE_IND = 1'b1;
        trace(40);
        for (int i = 0; i < 40; i++) drops += int'(!tce_tr[i]);
        tests++; if (drops != 0 || SPEED !== 2'b10) begin fails++; $display("FAIL ge_hold_short: got drops=%0d spd=%b want 0/10", drops, SPEED); end
        GMII_GE_IND = 1'b0;
        MII_100_IND = 1'b1;
        trace(125);
        lcs = 0;
        for (int i = 0; i < 125; i++) lcs += int'(lc_tr[i]);
        tests++; if (tce_tr[106] !== 1'b1 || tce_tr[107] !== 1'b0) begin fails++; $display("FAIL ge_hold_expire: got %b%b want 10", tce_tr[106], tce_tr[107]); end
        tests++; if (spd_tr[110] !== 2'b10 || spd_tr[111] !== 2'b01 || sel_tr[111] !== 1'b0) begin fails++; $display("FAIL ge_hold_swap: got %b->%b sel=%b want 10->01 sel=0", spd_tr[110], spd_tr[111], sel_tr[111]); end
        tests++; if (lcs != 1 || tce_tr[114] !== 1'b1 || SWITCH_CNT !== 8'd2) begin fails++; $display("FAIL ge_hold_done: got lc=%0d tce=%b cnt=%0d want 1/1/2", lcs, tce_tr[114], SWITCH_CNT); end
    endtask

    task automatic test_glitch();
        int drops;
        MII_100_IND = 1'b0;
        repeat (3) tick();
        MII_100_IND = 1'b1;
        trace(20);
        drops = 0;
        for (int i = 0; i < 20; i++) drops += int'(!tce_tr[i]);
        tests++; if (drops != 0 || SPEED !== 2'b01 || SWITCH_CNT !== 8'd2) begin fails++; $display("FAIL glitch: got drops=%0d spd=%b cnt=%0d want 0/01/2", drops, SPEED, SWITCH_CNT); end
    endtask

    task automatic test_force();
        int lcs;
        MII_100_IND = 1'b0;
        trace(20);
        tests++; if (spd_tr[11] !== 2'b00 || spd_tr[10] !== 2'b01 || SWITCH_CNT !== 8'd3) begin fails++; $display("FAIL to_10m: got %b->%b cnt=%0d want 01->00 cnt=3", spd_tr[10], spd_tr[11], SWITCH_CNT); end
        FORCE_MODE = 2'b11;
        FORCE_EN = 1'b1;
        trace(12);
        tests++; if (tce_tr[0] !== 1'b0 || spd_tr[3] !== 2'b00 || spd_tr[4] !== 2'b10 || sel_tr[4] !== 1'b1 || lc_tr[4] !== 1'b1) begin fails++; $display("FAIL force_ge: got tce0=%b spd=%b->%b sel=%b lc=%b want 0 00->10 1 1", tce_tr[0], spd_tr[3], spd_tr[4], sel_tr[4], lc_tr[4]); end
        tests++; if (tce_tr[6] !== 1'b0 || tce_tr[7] !== 1'b1 || SWITCH_CNT !== 8'd4) begin fails++; $display("FAIL force_ge_settle: got %b%b cnt=%0d want 01 cnt=4", tce_tr[6], tce_tr[7], SWITCH_CNT); end
        FORCE_EN = 1'b0;
        trace(12);
        tests++; if (spd_tr[4] !== 2'b00 || sel_tr[4] !== 1'b0 || SWITCH_CNT !== 8'd5) begin fails++; $display("FAIL force_release: got spd=%b sel=%b cnt=%0d want 00/0/5", spd_tr[4], sel_tr[4], SWITCH_CNT); end
        FORCE_EN = 1'b1;
        tick();
        tick();
        FORCE_EN = 1'b0;
        tests++; if (TX_CE !== 1'b0 || SWITCH_BUSY !== 1'b1) begin fails++; $display("FAIL revert_in_gate: got tce=%b busy=%b want 0/1", TX_CE, SWITCH_BUSY); end
        trace(12);
        lcs = 0;
        for (int i = 0; i < 12; i++) lcs += int'(lc_tr[i]) + int'(spd_tr[i] != 2'b00);
        tests++; if (lcs != 0 || SWITCH_CNT !== 8'd5) begin fails++; $display("FAIL revert_no_change: got events=%0d cnt=%0d want 0/5", lcs, SWITCH_CNT); end
        tests++; if (tce_tr[4] !== 1'b0 || tce_tr[5] !== 1'b1 || SWITCH_BUSY !== 1'b0) begin fails++; $display("FAIL revert_idle: got %b%b busy=%b want 01 busy=0", tce_tr[4], tce_tr[5], SWITCH_BUSY); end
    endtask

    task automatic test_saturate();
        int exp_cnt, k;
        exp_cnt = 5;
        FORCE_EN = 1'b1;
        for (int i = 0; i < 260; i++) begin
            FORCE_MODE = (i % 2 == 0) ? 2'b01 : 2'b00;
            k = 0;
            do begin tick(); k++; end while (!(SPEED == FORCE_MODE && !SWITCH_BUSY) && k < 30);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (k >= 30) begin tests++; fails++; $display("FAIL sat_timeout: switch %0d got spd=%b want %b", i, SPEED, FORCE_MODE); end
            if (i == 100) begin tests++; if (SWITCH_CNT !== 8'(exp_cnt)) begin fails++; $display("FAIL sat_mid: got %0d want %0d", SWITCH_CNT, exp_cnt); end end
        end
        tests++; if (SWITCH_CNT !== 8'd255 || SPEED !== 2'b00) begin fails++; $display("FAIL sat_final: got cnt=%0d spd=%b want 255/00", SWITCH_CNT, SPEED); end
    endtask

    task automatic test_reset_mid();
        int k;
        FORCE_MODE = 2'b10;
        k = 0;
        do begin tick(); k++; end while (!(SPEED == 2'b10 && !SWITCH_BUSY) && k < 30);
        tests++; if (SPEED !== 2'b10 || CLK_SEL !== 1'b1 || SWITCH_CNT !== 8'd255) begin fails++; $display("FAIL pre_reset: got spd=%b sel=%b cnt=%0d want 10/1/255", SPEED, CLK_SEL, SWITCH_CNT); end
        FORCE_MODE = 2'b01;
        tick();
        tick();
        #1 RESET = 1'b1;
        #1;
        tests++; if (TX_CE !== 1'b0 || SPEED !== 2'b00 || CLK_SEL !== 1'b0) begin fails++; $display("FAIL async_reset_out: got tce=%b spd=%b sel=%b want 0/00/0", TX_CE, SPEED, CLK_SEL); end
        tests++; if (SWITCH_CNT !== 8'd0 || SWITCH_BUSY !== 1'b1 || LINK_CHANGE !== 1'b0) begin fails++; $display("FAIL async_reset_status: got cnt=%0d busy=%b lc=%b want 0/1/0", SWITCH_CNT, SWITCH_BUSY, LINK_CHANGE); end
        FORCE_EN = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ge_up();
        test_ge_hold();
        test_glitch();
        test_force();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ge_speed_sel.md
# ge_speed_sel

Parametrised GMII/MII link-speed tracker and transmit-clock switch controller for the Ethernet MAC clocking path. It synchronises and debounces the PHY speed indications and applies hold-off hysteresis on GE loss. It then drives the select of the external 125 MHz / PHY-TXCLK clock mux through a gated, glitch-safe switch sequence. It sits between the PHY status pins and the BUFGCE/BUFGMUX pair that feeds ENET0_GMII_TX_CLK.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for each indication input (≥2).
- DEBOUNCE, 16: consecutive stable cycles required before a synchronised speed is accepted (≥1).
- HOLD_CYCLES, 24'hFFFFFF: cycles GE must stay absent before downgrading from GE.
- GUARD_CYCLES, 8: cycles TX_CE is held low before and after a mux select change (≥1).
- TIMER_W, 28: width of the hold timer; must hold HOLD_CYCLES.

Ports:
- SYS_CLK  in  1  free-running 125 MHz clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- GMII_GE_IND  in  1  PHY 1000M indication, asynchronous.
- MII_100_IND  in  1  PHY 100M indication, asynchronous.
- FORCE_EN  in  1  software override enable (synchronous to SYS_CLK).
- FORCE_MODE  in  2  forced speed: 00=10M, 01=100M, 10/11=GE.
- SPEED  out  2  current applied speed: 00=10M, 01=100M, 10=GE.
- CLK_SEL  out  1  mux select: 1=internal 125 MHz, 0=PHY GMII_TXCLK.
- TX_CE  out  1  clock enable to the TX clock buffer; 0 gates the clock.
- SWITCH_BUSY  out  1  high whenever the FSM is not in IDLE.
- LINK_CHANGE  out  1  one-cycle pulse when SPEED changes.
- SWITCH_CNT  out  8  saturating count of applied speed changes.

## Operation
- Reset state (while RESET is high): SPEED=00, CLK_SEL=0, TX_CE=0, SWITCH_BUSY=1, LINK_CHANGE=0, SWITCH_CNT=0, all synchronisers, debounce and timer registers cleared, FSM=SETTLE with guard counter at 0.
- Raw speed: the synchronised value is GE if GE_IND=1 (GE wins when both are high), 100M if only 100_IND=1, and 10M otherwise.
- Debounce: the candidate register reloads and its counter clears on any change of the raw speed. The accepted speed updates when the candidate has been stable DEBOUNCE cycles.
- GE hysteresis: accepted GE raises the target to GE immediately. When the accepted speed leaves GE, the target stays GE until the hold timer reaches HOLD_CYCLES, then takes the accepted speed. The timer clears on every cycle the accepted speed is GE. Changes between 100M and 10M apply to the target immediately.
- Override: FORCE_EN=1 makes the target equal FORCE_MODE (11 maps to 10), bypassing debounce and hold. Dropping FORCE_EN reverts the target to the tracked value on the next cycle.
- FSM states:
  - IDLE: TX_CE=1. When target ≠ SPEED, go to GATE, clear the guard counter, and drive TX_CE=0.
  - GATE: hold for GUARD_CYCLES cycles, then go to SWAP.
  - SWAP (1 cycle): load SPEED from the current target and set CLK_SEL=(target==GE). If the loaded value differs from the old SPEED, pulse LINK_CHANGE and increment SWITCH_CNT, saturating at 255. If the target has reverted to the old SPEED, nothing changes and no pulse is generated. Then go to SETTLE.
  - SETTLE: hold for GUARD_CYCLES cycles, then go to IDLE.
- Target changes during GATE or SETTLE are not lost. SWAP uses the newest target, and IDLE re-compares on entry.
- Every speed change goes through the gate sequence, including 100M↔10M (the PHY TXCLK frequency changes).

## Timing
- An indication edge first sampled at cycle 0 reaches the accepted speed at cycle SYNC_STAGES+DEBOUNCE, absent other hysteresis.
- TX_CE falls one cycle after the target changes.
- SWAP occurs GUARD_CYCLES cycles after TX_CE falls. CLK_SEL, SPEED and LINK_CHANGE update at the end of SWAP.
- TX_CE rises GUARD_CYCLES+1 cycles after SWAP.
- The GE downgrade adds HOLD_CYCLES cycles after acceptance.
- After RESET deasserts, TX_CE rises after GUARD_CYCLES cycles in SETTLE with SPEED=00 and CLK_SEL=0. An indication already present then triggers a normal switch.
- Asserting RESET mid-sequence returns all outputs to their reset values asynchronously.
- CLK_SEL never changes while TX_CE=1.

## Test plan
Bench parameters: SYNC_STAGES=2, DEBOUNCE=4, GUARD_CYCLES=3, HOLD_CYCLES=100.
- Reset release with both indications low -> TX_CE=0 for 3 cycles then 1; SPEED=00, CLK_SEL=0, no LINK_CHANGE.
- GE_IND rises -> TX_CE falls 7 cycles later; SPEED=10 and CLK_SEL=1 after 3 more cycles with a single LINK_CHANGE; TX_CE=1 after 4 more; SWITCH_CNT=1.
- From GE, drop GE_IND for 60 cycles then restore -> no TX_CE drop, SPEED stays 10. Drop it for 120 cycles with 100_IND=1 -> switch to SPEED=01, CLK_SEL=0.
- Glitch a 3-cycle pulse on MII_100_IND -> no target change, TX_CE stays 1.
- FORCE_EN=1 with FORCE_MODE=11 while at 10M -> switch to SPEED=10. Deassert FORCE_EN during GATE while the tracked speed is 00 -> SWAP performs no change, no LINK_CHANGE, return to IDLE.
- Perform 260 alternating forced switches -> SWITCH_CNT saturates at 255. Assert RESET during GATE -> TX_CE=0, SPEED=00, SWITCH_CNT=0 immediately.
